// File: rtl/serializer_pkg.sv
// serializer_pkg: FSM state encoding and serial frame line levels shared by the serializer.
package serializer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from an upstream FIFO and sends each as a framed serial word
// (start bit, LSB-first payload, odd parity, stop bit).
module fifo_serializer
    import serializer_pkg::*;
#(
    parameter int WORD_WIDTH = 64,
    parameter int CNT_BITS   = $clog2(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  read_n,
    input  logic                  tx_enable,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic [15:0]           word_count
);

    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WORD_WIDTH - 1);

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  parity_q, parity_d;
    logic [15:0]           word_count_q, word_count_d;
    logic                  accept;

    assign accept = tx_enable && !fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            parity_q     <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            parity_q     <= parity_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        parity_d     = parity_q;
        word_count_d = word_count_q;
        case (state_q)
            IDLE:    state_d = accept ? POP : IDLE;
            POP:     state_d = LOAD;
            LOAD: begin
                shift_d  = fifo_data;
                parity_d = ~^fifo_data;
                state_d  = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST_BIT) ? PARITY : DATA;
            end
            PARITY:  state_d = STOP;
            STOP: begin
                word_count_d = (&word_count_q) ? word_count_q : word_count_q + 16'd1;
                state_d      = accept ? POP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state so no input reaches an output combinationally.
    assign read_n     = (state_q != POP);
    assign tx_busy    = (state_q != IDLE);
    assign word_count = word_count_q;
    assign tx_out     = (state_q == START)  ? START_BIT :
                        (state_q == DATA)   ? shift_q[0] :
                        (state_q == PARITY) ? parity_q :
                        (state_q == STOP)   ? STOP_BIT : IDLE_LEVEL;

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: random and directed stimulus against a frame-level scoreboard of the serializer.
module tb_fifo_serializer;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tx_enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data = '0;
    logic          read_n;
    logic          tx_out;
    logic          tx_busy;
    logic [15:0]   word_count;

    fifo_serializer #(.WORD_WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .read_n     (read_n),
        .tx_enable  (tx_enable),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO model: mem doubles as the scoreboard of words expected on the line, in order.
    logic [W-1:0] mem [256];
    int wp = 0;
    int rp = 0;

    always @(posedge clk) begin
        if (reset_n && !read_n) begin
            fifo_data  <= mem[8'(rp)];
            rp         <= rp + 1;
            fifo_empty <= (wp == rp + 1);
        end else begin
            fifo_empty <= (wp == rp);
        end
    end

    task automatic push(input logic [W-1:0] w);
        mem[8'(wp)] = w;
        wp++;
    endtask

    // Frame monitor: decodes the line per frame and compares against the scoreboard word.
    int           phase = 0;
    int           idx = 0;
    int           mi = 0;
    int           prev_start = 0;
    int           last_start = 0;
    logic [W-1:0] cur = '0;
    logic [15:0]  model_cnt = '0;
    bit           cnt_pending = 1'b0;
    int           pre_gen = 0;
    int           seen_gen = 0;
    logic [15:0]  pre_val = '0;

    function automatic logic frame_bit(input logic [W-1:0] w, input int i);
        if (i == 0) return 1'b0;
        if (i <= W) return w[i-1];
        if (i == W + 1) return ($countones(w) % 2 == 0);
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            phase       = 0;
            cnt_pending = 1'b0;
            model_cnt   = '0;
        end else begin
            if (pre_gen != seen_gen) begin
                model_cnt = pre_val;
                seen_gen  = pre_gen;
            end
            if (cnt_pending) begin
                check("word_count", 64'(word_count), 64'(model_cnt));
                cnt_pending = 1'b0;
            end
            case (phase)
                0: begin
                    if (!read_n) begin
                        check("pop_has_word", 64'(mi < wp), 64'd1);
                        cur = mem[8'(mi)];
                        mi++;
                        phase = 1;
                    end else begin
                        check("idle_line", 64'(tx_out), 64'd1);
                    end
                end
                1: begin
                    check("load_line", 64'(tx_out), 64'd1);
                    check("load_read_n", 64'(read_n), 64'd1);
                    phase = 2;
                    idx = 0;
                end
                default: begin
                    check($sformatf("frame_bit%0d", idx), 64'(tx_out), 64'(frame_bit(cur, idx)));
                    check("frame_busy", 64'(tx_busy), 64'd1);
                    if (idx == 0) begin
                        prev_start = last_start;
                        last_start = cyc;
                    end
                    if (idx == W + 2) begin
                        phase = 0;
                        model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
                        cnt_pending = 1'b1;
                    end else begin
                        idx++;
                    end
                end
            endcase
        end
    end

    task automatic drain(input int lim);
        int n = 0;
        while (!(rp == wp && mi == wp && phase == 0 && !tx_busy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < lim), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_pop();
        int n = 0;
        while (read_n !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pop_timeout", 64'(n < 100), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rp_snap;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_n", 64'(read_n), 64'd1);
        check("rst_tx_out", 64'(tx_out), 64'd1);
        check("rst_busy", 64'(tx_busy), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single 8'hA5 frame
        push(8'hA5);
        tx_enable = 1'b1;
        drain(200);
        check("a5_count", 64'(word_count), 64'd1);
        check("a5_pops", 64'(rp), 64'd1);

        // Back-to-back 8'h01 then 8'hFF
        @(posedge clk);
        #1;
        push(8'h01);
        push(8'hFF);
        drain(200);
        check("b2b_start_gap", 64'(last_start - prev_start), 64'(W + 5));
        check("b2b_count", 64'(word_count), 64'd3);

        // Empty FIFO with enable held high
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("empty_read_n", 64'(read_n), 64'd1);
            check("empty_tx_out", 64'(tx_out), 64'd1);
            check("empty_busy", 64'(tx_busy), 64'd0);
        end

        // tx_enable dropped in the third DATA cycle with two words queued
        @(posedge clk);
        #1;
        rp_snap = rp;
        push(8'h3C);
        push(8'hC7);
        wait_pop();
        repeat (5) @(posedge clk);
        #1 tx_enable = 1'b0;
        for (int n = 0; n < 40 && tx_busy; n++) @(negedge clk);
        check("drop_idle", 64'(tx_busy), 64'd0);
        check("drop_one_pop", 64'(rp - rp_snap), 64'd1);
        repeat (20) @(negedge clk);
        check("drop_stays_idle", 64'(tx_busy), 64'd0);
        check("drop_no_second_pop", 64'(rp - rp_snap), 64'd1);
        check("drop_count", 64'(word_count), 64'd4);
        @(posedge clk);
        #1 tx_enable = 1'b1;
        drain(200);
        check("drop_resume_count", 64'(word_count), 64'd5);

        // Reset pulse in the fifth DATA cycle
        @(posedge clk);
        #1;
        push(8'h96);
        wait_pop();
        repeat (7) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_tx_out", 64'(tx_out), 64'd1);
        check("mrst_busy", 64'(tx_busy), 64'd0);
        check("mrst_count", 64'(word_count), 64'd0);
        check("mrst_read_n", 64'(read_n), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        push(8'h5A);
        drain(200);
        check("post_rst_count", 64'(word_count), 64'd1);

        // Random words with random enable gating
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 9) == 0) push(W'($urandom));
            tx_enable = ($urandom_range(0, 3) != 0);
        end
        tx_enable = 1'b1;
        drain(3000);

        // Saturation of word_count
        @(posedge clk);
        #1;
        pre_val = 16'hFFFE;
        pre_gen++;
        force dut.word_count_q = 16'hFFFE;
        @(posedge clk);
        #1 release dut.word_count_q;
        push(8'h11);
        push(8'hEE);
        drain(200);
        check("sat_count", 64'(word_count), 64'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
